// File: rtl/sram_fifo_pkg.sv
// Shared definitions for the SRAM-backed FIFO controller.
//   grant_e           : which side owned the single SRAM port most recently
//   SRAM_DATA_WIDTH   : word size of the generated sram_32_128_freepdk45 macro
//   SRAM_ADDR_WIDTH   : address width of that macro
//   OBUF_DEPTH        : entries in the output prefetch buffer
package sram_fifo_pkg;

  localparam int SRAM_DATA_WIDTH = 32;
  localparam int SRAM_ADDR_WIDTH = 7;
  localparam int OBUF_DEPTH      = 2;

  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry output register FIFO. Head entry drives the consumer directly.
//   clk, reset    : clock, async active-high reset
//   cap_valid_i   : SRAM read data is landing this cycle
//   cap_data_i    : the SRAM read data
//   pop_i         : consumer ready (only acts while the buffer is non-empty)
//   data_o        : head entry
//   valid_o       : buffer non-empty
//   count_o       : entries held (0..2)
module sram_fifo_obuf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap_valid_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic [1:0]            count_o
);

  logic [OBUF_DEPTH-1:0][DATA_WIDTH-1:0] ent_q, ent_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] slot;
  logic       pop;

  always_comb begin
    ent_d = ent_q;
    cnt_d = cnt_q;
    pop   = pop_i && (cnt_q != 2'd0);
    // Capture lands in the first free slot as seen after this cycle's pop.
    slot  = cnt_q - {1'b0, pop};
    if (pop) ent_d[0] = ent_q[1];
    if (cap_valid_i) begin
      if (slot == 2'd0) ent_d[0] = cap_data_i;
      else              ent_d[1] = cap_data_i;
    end
    cnt_d = cnt_q + {1'b0, cap_valid_i} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = ent_q[0];
  assign valid_o = (cnt_q != 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Ready/valid FIFO controller over one single-port SRAM macro (1-cycle
// registered read). A 2-entry prefetch buffer hides the read latency and the
// single-port arbitration from the consumer.
//   clk, reset                  : clock (shared with SRAM clk0), async reset
//   push_valid/ready/data       : producer side
//   pop_valid/ready/data        : consumer side
//   count                       : words held (SRAM + in-flight + buffer)
//   sram_csb/web/addr/din/dout  : macro port 0
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH+1:0] count,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [2:0]          OBUF_C  = 3'(OBUF_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic                  inflight_q, inflight_d;
  grant_e                last_grant_q, last_grant_d;

  logic       not_full, wr_elig, rd_elig, wr_gnt, rd_gnt;
  logic [1:0] buf_cnt;

  assign not_full = (mem_count_q < DEPTH_C);
  // reset gates the producer so no write strobe escapes while held in reset.
  assign wr_elig  = !reset && push_valid && not_full;
  // Registered state only: the consumer's ready never feeds the SRAM port.
  assign rd_elig  = (mem_count_q != '0) &&
                    (({1'b0, buf_cnt} + {2'b0, inflight_q}) < OBUF_C);

  // Round-robin on contention: the side that did not win last time goes.
  assign rd_gnt = rd_elig && (!wr_elig || (last_grant_q == GRANT_WRITE));
  assign wr_gnt = wr_elig && !rd_gnt;

  assign push_ready = !reset && not_full && !rd_gnt;

  always_comb begin
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    sram_addr = '0;
    sram_din  = '0;
    if (wr_gnt) begin
      sram_csb  = 1'b0;
      sram_web  = 1'b0;
      sram_addr = wr_ptr_q;
      sram_din  = push_data;
    end else if (rd_gnt) begin
      sram_csb  = 1'b0;
      sram_addr = rd_ptr_q;
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q + ADDR_WIDTH'(wr_gnt);
    rd_ptr_d     = rd_ptr_q + ADDR_WIDTH'(rd_gnt);
    mem_count_d  = mem_count_q + (ADDR_WIDTH+1)'(wr_gnt) - (ADDR_WIDTH+1)'(rd_gnt);
    inflight_d   = rd_gnt;
    last_grant_d = last_grant_q;
    if (rd_gnt)      last_grant_d = GRANT_READ;
    else if (wr_gnt) last_grant_d = GRANT_WRITE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_count_q  <= '0;
      inflight_q   <= 1'b0;
      last_grant_q <= GRANT_READ;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_count_q  <= mem_count_d;
      inflight_q   <= inflight_d;
      last_grant_q <= last_grant_d;
    end
  end

  sram_fifo_obuf #(.DATA_WIDTH(DATA_WIDTH)) u_obuf (
    .clk         (clk),
    .reset       (reset),
    .cap_valid_i (inflight_q),
    .cap_data_i  (sram_dout),
    .pop_i       (pop_ready),
    .data_o      (pop_data),
    .valid_o     (pop_valid),
    .count_o     (buf_cnt)
  );

  assign count = (ADDR_WIDTH+2)'(mem_count_q) + (ADDR_WIDTH+2)'(inflight_q) +
                 (ADDR_WIDTH+2)'(buf_cnt);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
module tb_sram_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          push_valid, push_ready, pop_valid, pop_ready;
  logic [DW-1:0] push_data, pop_data;
  logic [AW+1:0] count;
  logic          sram_csb, sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .count(count),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // Behavioural single-port macro: one-cycle registered read.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      else           sram_dout      <= mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mid(); @(negedge clk); endtask
  task automatic nxt(); @(posedge clk); #1; endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] d, exp_w;
  int            got, pushes, pops, nacc;
  logic          prev_web;

  initial begin
    reset = 1'b1; push_valid = 1'b1; push_data = 32'h1234_5678; pop_ready = 1'b0;
    sram_dout = '0;

    // ---- reset with a pending push
    mid();
    chk("rst_push_ready", push_ready, 0);
    chk("rst_csb", sram_csb, 1);
    chk("rst_web", sram_web, 1);
    chk("rst_din", sram_din, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_count", count, 0);
    nxt();
    reset = 1'b0; push_valid = 1'b0;
    mid();
    chk("post_rst_push_ready", push_ready, 1);
    chk("post_rst_csb_idle", sram_csb, 1);
    nxt();

    // ---- single push, latency to pop
    push_valid = 1'b1; push_data = 32'hDEAD_BEEF;
    mid();
    chk("c0_csb", sram_csb, 0);
    chk("c0_web", sram_web, 0);
    chk("c0_addr", sram_addr, 0);
    chk("c0_din", sram_din, 32'hDEAD_BEEF);
    nxt(); push_valid = 1'b0;
    mid();
    chk("c1_csb", sram_csb, 0);
    chk("c1_web", sram_web, 1);
    chk("c1_addr", sram_addr, 0);
    chk("c1_pop_valid", pop_valid, 0);
    nxt(); mid();
    chk("c2_pop_valid", pop_valid, 0);
    chk("c2_count", count, 1);
    nxt(); pop_ready = 1'b1;
    mid();
    chk("c3_pop_valid", pop_valid, 1);
    chk("c3_pop_data", pop_data, 32'hDEAD_BEEF);
    nxt(); pop_ready = 1'b0;
    mid();
    chk("c4_pop_valid", pop_valid, 0);
    chk("c4_count", count, 0);
    nxt();

    // ---- fill 130 words with consumer stalled (SRAM wraps from addr 1)
    nacc = 0;
    for (int c = 0; c < 400 && nacc < 130; c++) begin
      push_valid = 1'b1; push_data = nacc;
      mid();
      if (push_ready) nacc++;
      nxt();
    end
    chk("fill_accepted", nacc, 130);
    push_valid = 1'b1; push_data = 32'd999;
    mid();
    chk("full_count", count, 130);
    chk("full_push_ready", push_ready, 0);
    chk("full_pop_valid", pop_valid, 1);
    nxt();
    // consumer stall: buffer full, SRAM full -> port idle, head steady
    for (int c = 0; c < 5; c++) begin
      mid();
      chk("stall_csb", sram_csb, 1);
      chk("stall_pop_data", pop_data, 0);
      chk("stall_count", count, 130);
      nxt();
    end
    push_valid = 1'b0; pop_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 600 && got < 130; c++) begin
      mid();
      if (pop_valid) begin
        chk("drain_data", pop_data, got);
        got++;
      end
      nxt();
    end
    chk("drain_got", got, 130);
    mid();
    chk("drain_count", count, 0);
    chk("drain_pop_valid", pop_valid, 0);
    nxt();

    // ---- continuous streaming, random data
    // 131 writes so far, so the write pointer sits at 3.
    pushes = 0; pops = 0; prev_web = 1'b1;
    for (int c = 0; c < 60; c++) begin
      push_valid = 1'b1; pop_ready = 1'b1; d = $urandom;
      push_data = d;
      mid();
      if (c == 0) begin
        chk("stream_first_addr", sram_addr, 3);
        chk("stream_first_web", sram_web, 0);
      end
      if (c >= 1) begin
        chk("stream_grant", sram_csb, 0);
        chk("stream_alternate", sram_web, !prev_web);
      end
      prev_web = sram_web;
      if (pop_valid) begin
        if (q.size() == 0) chk("stream_underflow", 1, 0);
        else begin
          exp_w = q.pop_front();
          chk("stream_data", pop_data, exp_w);
        end
        if (c >= 10 && c < 50) pops++;
      end
      if (push_ready) begin
        q.push_back(d);
        if (c >= 10 && c < 50) pushes++;
      end
      nxt();
    end
    chk("stream_push_rate", pushes, 20);
    chk("stream_pop_rate", pops, 20);
    push_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      mid();
      if (pop_valid) begin
        exp_w = q.pop_front();
        chk("stream_tail", pop_data, exp_w);
      end
      nxt();
    end
    chk("stream_left", q.size(), 0);
    mid();
    chk("stream_count", count, 0);
    nxt();

    // ---- reset while a read is in flight
    pop_ready = 1'b0; push_valid = 1'b1; push_data = 32'hCAFE_F00D;
    nxt(); push_valid = 1'b0;
    mid();
    chk("rif_read_grant", sram_web, 1);
    nxt();
    reset = 1'b1;
    mid();
    chk("rif_count", count, 0);
    chk("rif_pop_valid", pop_valid, 0);
    nxt(); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mid();
      chk("rif_post_pop_valid", pop_valid, 0);
      chk("rif_post_count", count, 0);
      chk("rif_post_csb", sram_csb, 1);
      nxt();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
- Ready/valid FIFO controller that uses one single-port OpenRAM macro (sram_32_128_freepdk45 by default) as its storage.
- Sits between a producer (e.g. conv-output stream) and a consumer (e.g. next-layer input stream).
- Drives the macro's csb0/web0/addr0/din0 and consumes its dout0, which has a one-cycle registered read latency.
- Hides the single-port restriction and the read latency behind a 2-entry output prefetch buffer.

Parameters:
- DATA_WIDTH, 32, word width; must equal the SRAM word size.
- ADDR_WIDTH, 7, SRAM address width.
- DEPTH, 1<<ADDR_WIDTH, number of SRAM words; derived, do not override.

Ports:
- clk  in  1  single clock; shared with the SRAM clk0.
- reset  in  1  asynchronous, active-high reset.
- push_valid  in  1  producer has a word.
- push_ready  out  1  controller accepts a word this cycle.
- push_data  in  DATA_WIDTH  producer word.
- pop_valid  out  1  head word available.
- pop_ready  in  1  consumer takes the head word.
- pop_data  out  DATA_WIDTH  head word.
- count  out  ADDR_WIDTH+2  total words held (SRAM + in-flight + output buffer).
- sram_csb  out  1  to csb0, active low.
- sram_web  out  1  to web0, active low write.
- sram_addr  out  ADDR_WIDTH  to addr0.
- sram_din  out  DATA_WIDTH  to din0.
- sram_dout  in  DATA_WIDTH  from dout0.

Behaviour:
- Reset (asynchronous assert, synchronous release): wr_ptr=0, rd_ptr=0, mem_count=0, inflight=0, buf_count=0, last_grant=READ.
  - Outputs during reset: pop_valid=0, push_ready=0, count=0, sram_csb=1, sram_web=1, sram_addr=0, sram_din=0.
  - Reset mid-operation discards any in-flight read. SRAM contents are not cleared.
- At most one SRAM operation per cycle. SRAM outputs are combinational from registered state plus push_valid.
- Eligibility:
  - wr_elig = push_valid && mem_count<DEPTH.
  - rd_elig = mem_count>0 && (buf_count+inflight)<2. This depends on registered state only and never on pop_ready.
- Grant:
  - Only one eligible: that side wins.
  - Both eligible: the side opposite to last_grant wins (round-robin).
  - last_grant updates only on an actual grant.
- push_ready = !reset && mem_count<DEPTH && !(read granted). A push handshake is therefore exactly a write grant.
- Write grant: sram_csb=0, sram_web=0, sram_addr=wr_ptr, sram_din=push_data. At the clock edge, wr_ptr++ (wraps modulo DEPTH) and mem_count++.
- Read grant: sram_csb=0, sram_web=1, sram_addr=rd_ptr. At the clock edge, rd_ptr++ (wraps) and mem_count--. inflight is set for exactly one cycle.
- Read capture: in the cycle after a read grant (inflight=1), sram_dout is written into the output buffer at the next edge.
  - Read data therefore becomes visible 2 cycles after the grant.
- Write-then-read of the same address in consecutive cycles returns the new data, because the macro writes at the negedge before the read negedge.
- Output buffer is a 2-entry register FIFO with head at pop_data. pop_valid = buf_count>0.
  - Capture and pop in the same cycle are legal; buf_count is unchanged.
  - Capture never overflows, guaranteed by rd_elig.
- Latency: push accepted in cycle 0 into an empty FIFO -> read granted cycle 1 -> pop_valid=1 in cycle 3.
- Full: mem_count==DEPTH deasserts push_ready. Total capacity is DEPTH+2.
- count = mem_count + inflight + buf_count.
- pop_data holds its value while pop_valid && !pop_ready.
- Invariant: sram_csb=1 whenever there is no grant.

Decomposition:
- Shared package sram_fifo_pkg holds:
  - grant_e enum {GRANT_READ, GRANT_WRITE}.
  - Localparams for DATA_WIDTH/ADDR_WIDTH defaults matching the generated macro.
  - OBUF_DEPTH=2.
- One sub-module, sram_fifo_obuf: the 2-entry output register FIFO with capture/pop/count.
- The SRAM macro is instantiated by the parent, not inside this block.

Test Plan:
- Reset with push_valid=1 -> push_ready=0, sram_csb=1, pop_valid=0, count=0. After release, push_ready=1 in the first cycle.
- Single push 0xDEADBEEF at cycle 0 into an empty FIFO:
  - sram_web=0, addr=0 in cycle 0.
  - Read addr=0 in cycle 1.
  - pop_valid=1 with pop_data=0xDEADBEEF in cycle 3.
- Push 130 words (values 0..129) with pop_ready=0:
  - Words 0,1 fill the output buffer.
  - push_ready drops after count reaches 130 (mem_count=128).
  - Then drain with pop_ready=1 -> values 0..129 in order, and wr_ptr/rd_ptr wrap correctly.
- push_valid=1 and pop_ready=1 continuously with a random stream:
  - SRAM ops alternate W/R once both are eligible.
  - No word is lost or reordered.
  - Steady-state throughput is 1 word per 2 cycles per side.
- Consumer stall (pop_ready=0 for 5 cycles) with the buffer full -> no read grants, pop_data stable, rd_elig=0.
- Assert reset one cycle after a read grant (inflight=1) -> the in-flight data is dropped, count=0, and pop_valid=0 after release.
